// File: rtl/reflet_float_to_int_pkg.sv
// Shared float-format helpers for the Reflet FPU plus the converter's FSM types.
// The FPU reuses the format-size functions and special-exponent predicates.
package reflet_float_to_int_pkg;

    function automatic int exponent_size(input int float_size);
        case (float_size)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            128:     return 15;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int float_size);
        return float_size - exponent_size(float_size) - 1;
    endfunction

    function automatic int exponent_bias(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

    // Fields are passed zero-extended to 64 bits so one definition serves every format.
    function automatic logic exp_all_ones(input logic [63:0] exp_field, input int es);
        logic [63:0] mask;
        mask = (64'd1 << es) - 64'd1;
        return (exp_field & mask) == mask;
    endfunction

    function automatic logic is_nan(input logic [63:0] exp_field, input logic [63:0] mant_field, input int es);
        return exp_all_ones(exp_field, es) && (mant_field != 64'd0);
    endfunction

    function automatic logic is_inf(input logic [63:0] exp_field, input logic [63:0] mant_field, input int es);
        return exp_all_ones(exp_field, es) && (mant_field == 64'd0);
    endfunction

    function automatic logic is_zero_or_denormal(input logic [63:0] exp_field);
        return exp_field == 64'd0;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    typedef enum logic [1:0] {RES_NORMAL, RES_ZERO, RES_NAN, RES_SAT} res_kind_t;

endpackage

// File: rtl/reflet_float_to_int_unpack.sv
// Splits a float into sign, unbiased exponent, hidden-bit mantissa and special flags.
module reflet_float_to_int_unpack
    import reflet_float_to_int_pkg::*;
#(
    parameter int float_size = 32
) (
    input  logic                                       [float_size-1:0] float_in,
    output logic                                                        sign,
    output logic signed [exponent_size(float_size):0]                   exp_unb,
    output logic        [mantissa_size(float_size):0]                   mant_h,
    output logic                                                        f_nan,
    output logic                                                        f_inf,
    output logic                                                        f_zero
);
    localparam int ES = exponent_size(float_size);
    localparam int MS = mantissa_size(float_size);

    logic [ES-1:0] exp_field;
    logic [MS-1:0] mant_field;

    assign sign       = float_in[float_size-1];
    assign exp_field  = float_in[float_size-2 -: ES];
    assign mant_field = float_in[MS-1:0];

    assign exp_unb = $signed({1'b0, exp_field}) - $signed((ES+1)'(exponent_bias(float_size)));
    assign mant_h  = {1'b1, mant_field};

    assign f_nan  = is_nan(64'(exp_field), 64'(mant_field), ES);
    assign f_inf  = is_inf(64'(exp_field), 64'(mant_field), ES);
    assign f_zero = is_zero_or_denormal(64'(exp_field));

endmodule

// File: rtl/reflet_float_to_int.sv
// Float to signed integer converter: bit-serial mantissa shifter, truncating toward
// zero, saturating on overflow, with a start/busy/out_valid handshake.
module reflet_float_to_int
    import reflet_float_to_int_pkg::*;
#(
    parameter int float_size = 32,
    parameter int int_size   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [float_size-1:0] float_in,
    output logic                  busy,
    output logic                  out_valid,
    output logic [int_size-1:0]   int_out,
    output logic                  overflow,
    output logic                  invalid
);
    localparam int ES = exponent_size(float_size);
    localparam int MS = mantissa_size(float_size);
    localparam int SW = (int_size > MS + 1) ? int_size : MS + 1;
    localparam int CW = $clog2(MS + int_size + 1);
    localparam logic [int_size-1:0] INT_MAX = {1'b0, {(int_size-1){1'b1}}};
    localparam logic [int_size-1:0] INT_MIN = {1'b1, {(int_size-1){1'b0}}};

    logic              sign;
    logic signed [ES:0] exp_unb;
    logic [MS:0]       mant_h;
    logic              f_nan, f_inf, f_zero;

    reflet_float_to_int_unpack #(.float_size(float_size)) u_unpack (
        .float_in (float_in),
        .sign     (sign),
        .exp_unb  (exp_unb),
        .mant_h   (mant_h),
        .f_nan    (f_nan),
        .f_inf    (f_inf),
        .f_zero   (f_zero)
    );

    state_t            state, next_state;
    res_kind_t         dec_kind, kind_r;
    logic              dec_ovf, dec_left;
    logic [CW-1:0]     dec_count, count_r;
    logic              sign_r, ovf_r, left_r;
    logic [SW-1:0]     shreg;
    logic              accept;
    logic [int_size-1:0] mag;

    assign busy   = (state != IDLE) || out_valid;
    assign accept = (state == IDLE) && start && !out_valid;
    assign mag    = shreg[int_size-1:0];

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int e;
        e         = int'(exp_unb);
        dec_kind  = RES_NORMAL;
        dec_ovf   = 1'b0;
        dec_left  = 1'b0;
        dec_count = '0;
        if (f_nan) begin
            dec_kind = RES_NAN;
        end else if (f_inf) begin
            dec_kind = RES_SAT;
            dec_ovf  = 1'b1;
        end else if (f_zero || e < 0) begin
            dec_kind = RES_ZERO;
        end else if (e > int_size - 2) begin
            // -2^(int_size-1) is representable exactly; only that case saturates cleanly.
            dec_kind = RES_SAT;
            dec_ovf  = !(sign && e == int_size - 1 && mant_h[MS-1:0] == '0);
        end else if (e < MS) begin
            dec_count = CW'(MS - e);
        end else begin
            dec_left  = 1'b1;
            dec_count = CW'(e - MS);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)
                         next_state = (dec_kind == RES_NORMAL && dec_count != '0) ? SHIFT : FINISH;
            SHIFT:   if (count_r == CW'(1)) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: the working registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_r  <= sign;
            kind_r  <= dec_kind;
            ovf_r   <= dec_ovf;
            left_r  <= dec_left;
            count_r <= dec_count;
            shreg   <= (dec_kind == RES_NORMAL) ? SW'(mant_h) : '0;
        end else if (state == SHIFT) begin
            shreg   <= left_r ? (shreg << 1) : (shreg >> 1);
            count_r <= count_r - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            int_out   <= '0;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == FINISH) begin
                out_valid <= 1'b1;
                overflow  <= (kind_r == RES_SAT) && ovf_r;
                invalid   <= (kind_r == RES_NAN);
                case (kind_r)
                    RES_NAN: int_out <= '0;
                    RES_SAT: int_out <= sign_r ? INT_MIN : INT_MAX;
                    default: int_out <= sign_r ? -mag : mag;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reflet_float_to_int.sv
// Directed bench for reflet_float_to_int (float32 -> int16) with hand-computed results.
module tb_reflet_float_to_int;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] float_in = '0;
    logic        busy, out_valid, overflow, invalid;
    logic [15:0] int_out;

    int          total = 0;
    int          bad = 0;
    logic [15:0] last_out = '0;

    reflet_float_to_int #(.float_size(32), .int_size(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .float_in  (float_in),
        .busy      (busy),
        .out_valid (out_valid),
        .int_out   (int_out),
        .overflow  (overflow),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Called on the first falling edge after the accepting edge; lat counts rising edges since accept.
    task automatic wait_valid(input bit scramble, output int lat, output bit busy_ok, output bit hold_ok);
        lat = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (int_out !== last_out) hold_ok = 1'b0;
            if (scramble) float_in = $urandom;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_result(input string tag, input logic [15:0] want, input bit w_ovf,
                                 input bit w_inv, input int w_lat, input bit scramble);
        int lat;
        bit busy_ok, hold_ok;
        wait_valid(scramble, lat, busy_ok, hold_ok);
        check({tag, " latency"}, lat, w_lat);
        check({tag, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
        check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, " int_out"}, {16'd0, int_out}, {16'd0, want});
        check({tag, " overflow"}, {31'd0, overflow}, {31'd0, w_ovf});
        check({tag, " invalid"}, {31'd0, invalid}, {31'd0, w_inv});
        last_out = want;
    endtask

    task automatic convert(input string tag, input logic [31:0] fin, input logic [15:0] want,
                           input bit w_ovf, input bit w_inv, input int w_lat);
        start    = 1'b1;
        float_in = fin;
        @(negedge clk);
        start    = 1'b0;
        float_in = ~fin;
        expect_result(tag, want, w_ovf, w_inv, w_lat, 1'b0);
        @(negedge clk);
        check({tag, " pulse"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset outputs", {busy, out_valid, overflow, invalid, int_out}, 32'd0);

        convert("one",      32'h3F800000, 16'h0001, 1'b0, 1'b0, 24);
        convert("m2p5",     32'hC0200000, 16'hFFFE, 1'b0, 1'b0, 23);
        convert("half",     32'h3F000000, 16'h0000, 1'b0, 1'b0, 1);
        convert("ten",      32'h41200000, 16'h000A, 1'b0, 1'b0, 21);
        convert("negzero",  32'h80000000, 16'h0000, 1'b0, 1'b0, 1);
        convert("max",      32'h46FFFE00, 16'h7FFF, 1'b0, 1'b0, 10);
        convert("big",      32'h471C4000, 16'h7FFF, 1'b1, 1'b0, 1);
        convert("min",      32'hC7000000, 16'h8000, 1'b0, 1'b0, 1);
        convert("below",    32'hC7800000, 16'h8000, 1'b1, 1'b0, 1);
        convert("pinf",     32'h7F800000, 16'h7FFF, 1'b1, 1'b0, 1);
        convert("ninf",     32'hFF800000, 16'h8000, 1'b1, 1'b0, 1);
        convert("nan",      32'h7FC00000, 16'h0000, 1'b0, 1'b1, 1);

        // start held high, operand changing every cycle
        start    = 1'b1;
        float_in = 32'h40000000;
        @(negedge clk);
        expect_result("hs two", 16'h0002, 1'b0, 1'b0, 23, 1'b1);
        float_in = 32'h40400000;
        @(negedge clk);
        check("hs no double accept", {30'd0, busy, out_valid}, 32'd0);
        float_in = 32'h40A00000;
        @(negedge clk);
        check("hs next accept", {31'd0, busy}, 32'd1);
        start    = 1'b0;
        float_in = 32'h7F800000;
        expect_result("hs five", 16'h0005, 1'b0, 1'b0, 22, 1'b0);
        @(negedge clk);

        // reset in the middle of a SHIFT sequence
        start    = 1'b1;
        float_in = 32'h3F800000;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst busy before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst state", {busy, out_valid, overflow, invalid, int_out}, 32'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst no late valid", seen, 0);
        last_out = '0;
        convert("after rst", 32'h41200000, 16'h000A, 1'b0, 1'b0, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
